// File: rtl/riscv_opcodes.sv
// riscv_opcodes
//    Shared constants for the RISC-V decode stage: one opcode value per major
//    instruction class, the 3-bit instruction-format enum and the funct7
//    values the OP / shift-immediate legality checks compare against.
//    No ports; imported with `import riscv_opcodes::*;`.
package riscv_opcodes;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [6:0] F7_BASE   = 7'h00;
   localparam logic [6:0] F7_ALT    = 7'h20;
   localparam logic [6:0] F7_MULDIV = 7'h01;

   typedef enum logic [2:0] {
      IT_R   = 3'd0,
      IT_I   = 3'd1,
      IT_S   = 3'd2,
      IT_B   = 3'd3,
      IT_U   = 3'd4,
      IT_J   = 3'd5,
      IT_SYS = 3'd6,
      IT_BAD = 3'd7
   } itype_t;

endpackage

// File: rtl/riscv_imm_gen.sv
// riscv_imm_gen
//    Combinational immediate extraction for one instruction word, selected
//    by the already-classified format. Signed formats are sign-extended to
//    XLEN; SYS (CSR address field) is zero-extended; R and BAD give 0.
// Ports:
//    instr  in   instr[31:7] (opcode bits are not needed here)
//    itype  in   instruction format
//    imm    out  XLEN-bit immediate
module riscv_imm_gen
   import riscv_opcodes::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:7]     instr,
   input  itype_t          itype,
   output logic [XLEN-1:0] imm
);

   always_comb begin
      imm = '0;
      case (itype)
         IT_I:    imm = XLEN'($signed(instr[31:20]));
         IT_S:    imm = XLEN'($signed({instr[31:25], instr[11:7]}));
         IT_B:    imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
         IT_U:    imm = XLEN'($signed({instr[31:12], 12'b0}));
         IT_J:    imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
         IT_SYS:  imm = XLEN'(instr[31:20]);
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/riscv_decode_stage.sv
// riscv_decode_stage
//    Registered RISC-V base-ISA decode stage. Each accepted instruction is
//    decoded combinationally and the decoded entry is stored in a 2-entry
//    skid FIFO (head register drives out_*, skid register holds the second
//    entry). Illegal instructions are flagged, reported as format BAD with
//    a zero immediate, and counted in a saturating counter.
//    Build option: define RISCV_DECODE_MEXT_EN to accept OP with
//    funct7=0x01 (M extension) as a legal R-format instruction.
// Ports:
//    clk, rst             clock, asynchronous active-high reset
//    in_valid/in_ready    fetch handshake; in_instr, in_pc payload
//    out_valid/out_ready  register-read handshake
//    out_pc, out_itype, out_rd, out_rs1, out_rs2, out_funct3, out_funct7,
//    out_imm, out_illegal decoded head entry (holds last popped when empty)
//    illegal_count        saturating count of accepted illegal instructions
module riscv_decode_stage
   import riscv_opcodes::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [XLEN-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output logic [2:0]       out_itype,
   output logic [4:0]       out_rd,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic [2:0]       out_funct3,
   output logic [6:0]       out_funct7,
   output logic [XLEN-1:0]  out_imm,
   output logic             out_illegal,
   output logic [CNT_W-1:0] illegal_count
);

   localparam int EW = 2*XLEN + 29;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [6:0]      shift_hi;
   itype_t          dec_type;
   itype_t          dec_itype;
   logic            dec_bad;
   logic [XLEN-1:0] dec_imm;

   logic [EW-1:0]   entry_in;
   logic [EW-1:0]   head;
   logic [EW-1:0]   skid;
   logic [1:0]      count;
   logic            push;
   logic            pop;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];

   // RV64 shift amounts are 6 bits, so instr[25] belongs to shamt there and
   // only instr[31:26] is constrained.
   assign shift_hi = (XLEN == 64) ? {in_instr[31:26], 1'b0} : in_instr[31:25];

   always_comb begin
      dec_type = IT_BAD;
      dec_bad  = 1'b0;
      case (opcode)
         OPC_LOAD: begin
            dec_type = IT_I;
            dec_bad  = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
         end
         OPC_MISC_MEM: begin
            dec_type = IT_I;
            dec_bad  = (funct3 > 3'd1);
         end
         OPC_OP_IMM: begin
            dec_type = IT_I;
            if (funct3 == 3'd1)
               dec_bad = (shift_hi != F7_BASE);
            else if (funct3 == 3'd5)
               dec_bad = (shift_hi != F7_BASE) && (shift_hi != F7_ALT);
         end
         OPC_JALR: begin
            dec_type = IT_I;
            dec_bad  = (funct3 != 3'd0);
         end
         OPC_STORE: begin
            dec_type = IT_S;
            dec_bad  = (funct3 > 3'd2);
         end
         OPC_BRANCH: begin
            dec_type = IT_B;
            dec_bad  = (funct3 == 3'd2) || (funct3 == 3'd3);
         end
         OPC_LUI, OPC_AUIPC: dec_type = IT_U;
         OPC_JAL:            dec_type = IT_J;
         OPC_OP: begin
            dec_type = IT_R;
            if (funct7 == F7_BASE)
               dec_bad = 1'b0;
            else if (funct7 == F7_ALT)
               dec_bad = !((funct3 == 3'd0) || (funct3 == 3'd5));
`ifdef RISCV_DECODE_MEXT_EN
            else if (funct7 == F7_MULDIV)
               dec_bad = 1'b0;
`endif
            else
               dec_bad = 1'b1;
         end
         OPC_SYSTEM: begin
            dec_type = IT_SYS;
            dec_bad  = (funct3 == 3'd4);
         end
         default: dec_bad = 1'b1;
      endcase
      if (in_instr[1:0] != 2'b11)
         dec_bad = 1'b1;
   end

   assign dec_itype = dec_bad ? IT_BAD : dec_type;

   riscv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr (in_instr[31:7]),
      .itype (dec_itype),
      .imm   (dec_imm)
   );

   assign entry_in = {in_pc, dec_itype, in_instr[11:7], in_instr[19:15], in_instr[24:20],
                      funct3, funct7, dec_imm, dec_bad};

   assign {out_pc, out_itype, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_illegal} = head;

   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // head is the oldest entry; when the FIFO empties it is left untouched so
   // out_* keep the last popped values. Push+pop can only occur with one
   // entry present (in_ready is low when full), so it just replaces head.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count         <= 2'd0;
         head          <= '0;
         skid          <= '0;
         illegal_count <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0)
                  head <= entry_in;
               else
                  skid <= entry_in;
               count <= count + 2'd1;
            end
            2'b01: begin
               if (count == 2'd2)
                  head <= skid;
               count <= count - 2'd1;
            end
            2'b11:   head <= entry_in;
            default: ;
         endcase
         if (push && dec_bad && (illegal_count != '1))
            illegal_count <= illegal_count + CNT_W'(1);
      end
   end

endmodule
